// File: rtl/gold_spawn_ctrl.sv
// gold_spawn_ctrl: spawns a falling gold coin, detects pickup or floor miss, and keeps a saturating coin count
module gold_spawn_ctrl #(
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int SPRITE_SIZE = 32,
    parameter int PLAYER_W    = 32,
    parameter int PLAYER_H    = 32,
    parameter int FALL_SPEED  = 2,
    parameter int SPAWN_DELAY = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        game_active,
    input  logic [10:0] player_x,
    input  logic [9:0]  player_y,
    output logic [10:0] gold_x,
    output logic [9:0]  gold_y,
    output logic        gold_visible,
    output logic        collect_pulse,
    output logic        miss_pulse,
    output logic [7:0]  gold_count
);
    localparam int CW = $clog2(SPAWN_DELAY + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SPAWN_DELAY - 1);
    localparam logic [10:0] COL_LIM = 11'(SCREEN_W - SPRITE_SIZE);
    localparam logic [11:0] FLOOR = 12'(SCREEN_H - SPRITE_SIZE);

    typedef enum logic [1:0] {IDLE, WAIT_SPAWN, FALLING} state_t;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [CW-1:0] cnt_q;
    logic [10:0]   gold_x_q;
    logic [9:0]    gold_y_q;
    logic          visible_q, collect_q, miss_q;
    logic [7:0]    count_q;

    logic [15:0] lfsr_d;
    logic [10:0] spawn_x_d;
    logic [11:0] gx, gy, px, py;
    logic        overlap, floor_hit;

    // Free-running LFSR step, folded spawn column, and 12-bit hit/floor tests
    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        spawn_x_d = ({1'b0, lfsr_q[9:0]} < COL_LIM) ? {1'b0, lfsr_q[9:0]} : {1'b0, lfsr_q[9:0]} - COL_LIM;
        gx        = {1'b0, gold_x_q};
        gy        = {2'b0, gold_y_q};
        px        = {1'b0, player_x};
        py        = {2'b0, player_y};
        overlap   = (gx < px + 12'(PLAYER_W)) && (px < gx + 12'(SPRITE_SIZE)) &&
                    (gy < py + 12'(PLAYER_H)) && (py < gy + 12'(SPRITE_SIZE));
        floor_hit = (gy + 12'(FALL_SPEED)) > FLOOR;
    end

    // Coin state machine with registered outputs; game_active low overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            cnt_q     <= '0;
            gold_x_q  <= '0;
            gold_y_q  <= '0;
            visible_q <= 1'b0;
            collect_q <= 1'b0;
            miss_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            collect_q <= 1'b0;
            miss_q    <= 1'b0;
            if (!game_active) begin
                state_q   <= IDLE;
                visible_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        count_q <= '0;
                        cnt_q   <= RELOAD;
                        state_q <= WAIT_SPAWN;
                    end
                    WAIT_SPAWN: if (frame_tick) begin
                        if (cnt_q == '0) begin
                            gold_x_q  <= spawn_x_d;
                            gold_y_q  <= '0;
                            visible_q <= 1'b1;
                            state_q   <= FALLING;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    FALLING: if (frame_tick) begin
                        if (overlap) begin
                            collect_q <= 1'b1;
                            count_q   <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                            visible_q <= 1'b0;
                            cnt_q     <= RELOAD;
                            state_q   <= WAIT_SPAWN;
                        end else if (floor_hit) begin
                            miss_q    <= 1'b1;
                            visible_q <= 1'b0;
                            cnt_q     <= RELOAD;
                            state_q   <= WAIT_SPAWN;
                        end else begin
                            gold_y_q <= gold_y_q + 10'(FALL_SPEED);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign gold_x        = gold_x_q;
    assign gold_y        = gold_y_q;
    assign gold_visible  = visible_q;
    assign collect_pulse = collect_q;
    assign miss_pulse    = miss_q;
    assign gold_count    = count_q;
endmodule

// File: tb/tb_gold_spawn_ctrl.sv
// tb_gold_spawn_ctrl: directed checks of spawn timing, falling, pickup, miss, saturation and reset
module tb_gold_spawn_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, game_active = 1'b1;
    logic [10:0] player_x = '0;
    logic [9:0]  player_y = '0;
    logic [10:0] gold_x;
    logic [9:0]  gold_y;
    logic        gold_visible, collect_pulse, miss_pulse;
    logic [7:0]  gold_count;
    logic [15:0] lfsr_m, snap;
    logic [10:0] exp_x;
    int checks = 0, failures = 0;

    gold_spawn_ctrl #(.SPAWN_DELAY(3)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_active(game_active),
        .player_x(player_x), .player_y(player_y), .gold_x(gold_x), .gold_y(gold_y),
        .gold_visible(gold_visible), .collect_pulse(collect_pulse), .miss_pulse(miss_pulse),
        .gold_count(gold_count)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, shift left, feedback into bit 0
    always @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_m <= 16'hACE1;
        else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

    function automatic logic [10:0] col_of(input logic [15:0] l);
        logic [10:0] c;
        c = {1'b0, l[9:0]};
        return (c < 11'd768) ? c : c - 11'd768;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        snap = lfsr_m;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic spawn();
        repeat (3) tick();
        exp_x = col_of(snap);
    endtask

    task automatic far();
        player_y = 10'd0;
        player_x = (exp_x < 11'd400) ? 11'd700 : 11'd0;
    endtask

    task automatic grab();
        spawn();
        player_x = exp_x;
        player_y = 10'd0;
        tick();
    endtask

    initial begin
        #12;
        chk("rst_x", gold_x, 0);
        chk("rst_y", gold_y, 0);
        chk("rst_vis", gold_visible, 0);
        chk("rst_col", collect_pulse, 0);
        chk("rst_miss", miss_pulse, 0);
        chk("rst_cnt", gold_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("wait1_vis", gold_visible, 0);
        tick();
        chk("wait2_vis", gold_visible, 0);
        tick();
        exp_x = col_of(snap);
        chk("spawn_vis", gold_visible, 1);
        chk("spawn_y", gold_y, 0);
        chk("spawn_x", gold_x, exp_x);
        chk("spawn_rng", gold_x <= 11'd767, 1);
        far();
        for (int k = 1; k <= 284; k++) begin
            tick();
            chk("fall_y", gold_y, 2 * k);
        end
        chk("fall_vis", gold_visible, 1);
        tick();
        chk("miss_p", miss_pulse, 1);
        chk("miss_col", collect_pulse, 0);
        chk("miss_vis", gold_visible, 0);
        chk("miss_cnt", gold_count, 0);
        chk("miss_y", gold_y, 568);
        @(negedge clk);
        chk("miss_1clk", miss_pulse, 0);
        spawn();
        chk("respawn_x", gold_x, exp_x);
        player_x = exp_x + 11'd10;
        player_y = 10'd100;
        repeat (35) tick();
        chk("pre_col_y", gold_y, 70);
        chk("pre_col_p", collect_pulse, 0);
        tick();
        chk("col_p", collect_pulse, 1);
        chk("col_cnt", gold_count, 1);
        chk("col_vis", gold_visible, 0);
        chk("col_miss", miss_pulse, 0);
        chk("col_y", gold_y, 70);
        @(negedge clk);
        chk("col_1clk", collect_pulse, 0);
        repeat (254) grab();
        chk("cnt_255", gold_count, 255);
        grab();
        chk("sat_cnt", gold_count, 255);
        chk("sat_col", collect_pulse, 1);
        spawn();
        far();
        repeat (284) tick();
        chk("edge_y", gold_y, 568);
        player_x = exp_x;
        player_y = 10'd560;
        tick();
        chk("both_col", collect_pulse, 1);
        chk("both_miss", miss_pulse, 0);
        chk("both_cnt", gold_count, 255);
        chk("both_vis", gold_visible, 0);
        spawn();
        far();
        repeat (10) tick();
        chk("drop_pre_y", gold_y, 20);
        @(negedge clk);
        game_active = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("drop_vis", gold_visible, 0);
        chk("drop_y", gold_y, 20);
        chk("drop_cnt", gold_count, 255);
        chk("drop_col", collect_pulse, 0);
        chk("drop_miss", miss_pulse, 0);
        @(negedge clk);
        game_active = 1'b1;
        @(negedge clk);
        chk("restart_cnt", gold_count, 0);
        grab();
        chk("restart_col", gold_count, 1);
        spawn();
        far();
        repeat (5) tick();
        chk("pre_arst_vis", gold_visible, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vis", gold_visible, 0);
        chk("arst_x", gold_x, 0);
        chk("arst_y", gold_y, 0);
        chk("arst_cnt", gold_count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gold_spawn_ctrl.md
Name: gold_spawn_ctrl

Overview:
- Frame-rate controller that owns the gold-coin object and drives the `gold_x`/`gold_y` position inputs of the gold sprite display stage.
- Spawns a coin at a pseudo-random column and drops it a fixed number of pixels per frame.
- Detects pickup by the player (bounding-box overlap) or a miss at the floor, then respawns after a delay.
- Keeps an 8-bit saturating collected-coin count for the score/HUD logic.

Parameters:
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in pixels
- SPRITE_SIZE, 32, coin sprite edge length (matches the 5-bit row/col of the display ROM)
- PLAYER_W, 32, player hitbox width
- PLAYER_H, 32, player hitbox height
- FALL_SPEED, 2, pixels added to gold_y per frame
- SPAWN_DELAY, 60, frame_ticks between respawn start and coin appearance; must be >= 1
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
- clk  input  1  system/pixel clock
- rst_n  input  1  asynchronous active-low reset
- frame_tick  input  1  one-clk pulse per frame (start of vertical blank)
- game_active  input  1  level high while the game is running
- player_x  input  11  player sprite left edge
- player_y  input  10  player sprite top edge
- gold_x  output  11  coin left edge, to the display stage
- gold_y  output  10  coin top edge, to the display stage
- gold_visible  output  1  coin drawn only when high
- collect_pulse  output  1  one-clk pulse on pickup
- miss_pulse  output  1  one-clk pulse when the coin reaches the floor uncollected
- gold_count  output  8  collected coins, saturating at 255

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE; gold_x=0, gold_y=0; gold_visible=0; pulses=0; gold_count=0; lfsr=LFSR_SEED; spawn counter=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts left every clk, feedback into bit0; free-running in all states.
- Spawn column:
  - c = lfsr[9:0].
  - gold_x = c if c < SCREEN_W-SPRITE_SIZE (768); else c-768, zero-extended to 11 bits.
  - Result is always in 0..767.
- State IDLE:
  - gold_visible=0.
  - When game_active=1: clear gold_count, load counter=SPAWN_DELAY-1, go to WAIT_SPAWN on the next clk.
- State WAIT_SPAWN:
  - gold_visible=0.
  - On frame_tick with counter=0: latch gold_x from the spawn column, set gold_y=0, set gold_visible=1, go to FALLING.
  - On frame_tick with counter≠0: decrement counter.
  - Result: the coin appears on the SPAWN_DELAY-th frame_tick after entry.
- State FALLING, evaluated only on frame_tick, in priority order, using the current gold and player positions:
  1. Overlap: gold_x < player_x+PLAYER_W AND player_x < gold_x+SPRITE_SIZE AND gold_y < player_y+PLAYER_H AND player_y < gold_y+SPRITE_SIZE.
     - Action: collect_pulse=1 for one clk; gold_count+=1 unless it is 255; gold_visible=0; reload counter; go to WAIT_SPAWN.
  2. Floor: gold_y+FALL_SPEED > SCREEN_H-SPRITE_SIZE (568).
     - Action: miss_pulse=1 for one clk; gold_visible=0; reload counter; go to WAIT_SPAWN.
  3. Otherwise: gold_y += FALL_SPEED.
  - Arithmetic: all compares and sums use 12-bit unsigned so edge sums cannot wrap.
- Output timing:
  - Outputs are registered and change only on the clk after the qualifying frame_tick.
  - gold_x/gold_y hold their last values while invisible.
- game_active=0 in any state:
  - Go to IDLE on the next clk; gold_visible=0; gold_count held; no pulses generated.
  - This takes precedence over a same-cycle frame_tick.
- Overlap and floor on the same tick: collect wins; only collect_pulse fires.
- frame_tick while not FALLING/WAIT_SPAWN: ignored.

Test Plan:
- Reset → all outputs 0, state IDLE. Release rst_n with game_active=1, SPAWN_DELAY=3 → gold_visible rises 1 clk after the 3rd frame_tick; gold_y=0; gold_x≤767.
- Falling, player at (0,0) far from a coin at x=400 → gold_y sequence 0,2,4,… per tick. At gold_y=568 the next tick gives miss_pulse=1 for one clk, gold_visible=0, gold_count unchanged.
- Player at (gold_x+10, 100) → collect_pulse fires on the tick where gold_y=70 (70<132 and 100<102); gold_count 0→1; coin disappears.
- Preload gold_count=255, then collect → count stays 255, collect_pulse still fires.
- Coin at gold_y=568 overlapping the player on the same tick → collect_pulse only, no miss_pulse.
- Drop game_active mid-fall, coincident with frame_tick → IDLE next clk, gold_visible=0, count held. Assert rst_n=0 asynchronously mid-fall → outputs 0 immediately, without waiting for a clk edge.
